fp_acc: RTL and testbench
=========================

# fp_acc

Floating-point accumulator stage that sits directly downstream of `fp_mult` inside each systolic processing element. It consumes the stream of IEEE-754 single-precision products and keeps a running sum. When the last product of a dot product arrives, it emits the finished sum with a one-cycle valid pulse. The adder is iterative and FSM-based, and it applies backpressure to the multiplier with `in_ready`.

## Interface
- `FLUSH_DENORM`, default 1: denormal operands and results are flushed to +0. Value 0 is not supported; elaboration errors out.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: product valid; driven from `fp_mult` `ready`.
- `in_p` input 32: FP32 product; driven from `fp_mult` `out_r`.
- `in_last` input 1: this product closes the current dot product.
- `in_ready` output 1: the block accepts `in_p` this cycle.
- `out_sum` output 32: final FP32 sum, held until the next result.
- `out_valid` output 1: one-cycle pulse when `out_sum` updates.

## Operation
- A transfer occurs when `in_valid && in_ready` at a rising edge. `in_p` and `in_last` are captured on that edge.
- FSM states: IDLE → ALIGN → ADD → NORM → PACK → IDLE, one cycle each.
  - IDLE: `in_ready`=1. On a transfer, go to ALIGN. Otherwise stay.
  - ALIGN: unpack `acc` and `in_p` with the hidden bit restored. Swap so the larger exponent is operand A. Right-shift B's 24-bit mantissa by the exponent difference into a 27-bit {mant, G, R, S} field. Shifts ≥ 27 leave only the sticky bit set.
  - ADD: if signs are equal, perform a 28-bit add. If signs differ, subtract the smaller magnitude from the larger, and the result sign is the sign of the larger magnitude.
  - NORM: on carry-out, right-shift by 1 and exp+1, with the shifted-out bit ORed into sticky. Otherwise left-shift by the leading-zero count and subtract it from exp. A zero magnitude gives +0.
  - PACK: round the result (see Configuration), then check exponents:
    - post-round exp ≥ 255 saturates to ±Inf (0x7F800000 / 0xFF800000);
    - exp ≤ 0 flushes to +0.
    - The result is written to `acc`. If the captured `in_last` is set, the result is also copied to `out_sum`, `out_valid`=1 and `acc` is cleared to +0.
- Inputs with exp=0 are treated as +0. Inputs with exp=255 are treated as ±Inf: the result is Inf with the same sign, and an opposite-sign Inf pair gives 0x7FC00000.
- `acc` is never visible except through `out_sum`.

## Timing
- Reset values: `out_sum`=0, `out_valid`=0, `in_ready`=1, `acc`=+0, state=IDLE.
- Throughput is one product per 5 cycles. `in_ready` is low for the 4 cycles after each transfer.
- Latency: `out_valid` asserts 4 cycles after the edge that transferred a product with `in_last`=1.
- `in_valid` held during busy cycles is not a transfer. The upstream stage must hold `in_p` stable until `in_ready`.
- A single product with `in_last`=1 yields that product, normalized and flushed.
- Reset asserted in any state aborts the in-flight add and discards `acc` and the captured operands. Outputs return to their reset values on the next edge.
- `out_valid` is never high in two consecutive cycles.

## Configuration
- `FP_ACC_RNE_EN` defined: round to nearest, ties to even, using G/R/S. A mantissa carry on rounding increments exp.
- `FP_ACC_RNE_EN` undefined: truncation (round toward zero). G/R/S are discarded and the rounding incrementer is not synthesized.

## Structure
- `fp_pkg` holds:
  - FP32 constants: EXP_W=8, MAN_W=23, BIAS=127;
  - QNAN, POS_INF and NEG_INF literals;
  - the packed struct typedef {sign, exp, man};
  - the `acc_state_t` enum.
- One sub-module, `fp_lzc`: a combinational 28-bit leading-zero counter used in NORM.

## Test plan
- Reset held for one edge, then products 0x40800000, 0x41800000, 0x42800000 and 0x43800000, the last one with `in_last` → `out_sum`=0x43AA0000 (340.0) with a one-cycle `out_valid`, and `acc` cleared afterwards.
- 0x40400000 then 0xC0400000 with `in_last` → `out_sum`=0x00000000.
- 0x3F800001 then 0x33800000 with `in_last` → 0x3F800002 with `FP_ACC_RNE_EN` defined, and 0x3F800001 without it.
- 0x00000001 alone with `in_last` → 0x00000000. 0x7F7FFFFF then 0x7F7FFFFF with `in_last` → 0x7F800000.
- `in_valid` held high continuously with a new product every cycle → `in_ready` pattern 1,0,0,0,0 repeating, and only products presented while `in_ready`=1 are summed.
- `rst`=0 asserted during ADD of a two-product sum, then restarted with 0x3F800000 and `in_last` → 0x3F800000, with no residue from the aborted sum.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: FP32 field constants, special-value literals, the FP32 field struct and the
// accumulator FSM state encoding shared by the fp_acc design files.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_PACK
   } acc_state_t;

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational 28-bit leading-zero counter; an all-zero input returns 28.
module fp_lzc (
   input  logic [27:0] value,
   output logic [4:0]  count
);

   always_comb begin
      count = 5'd28;
      // Scanning upward lets the most significant set bit win.
      for (int i = 0; i < 28; i++) begin
         if (value[i]) count = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fp_acc.sv
// fp_acc: iterative FP32 accumulator, IDLE->ALIGN->ADD->NORM->PACK, one product per 5 cycles.
// Define FP_ACC_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_acc
   import fp_pkg::*;
#(
   parameter int FLUSH_DENORM = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_p,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_sum,
   output logic        out_valid
);

   localparam logic signed [9:0] EXP_SAT = 10'(2 * BIAS + 1);

   generate
      if (FLUSH_DENORM != 1) begin : g_bad_cfg
         $error("fp_acc: only FLUSH_DENORM=1 is supported");
      end
   endgenerate

   acc_state_t        state, state_next;
   fp32_t             acc, cap_p;
   logic              cap_last;
   logic              al_special, a_sign, b_sign;
   logic [31:0]       al_special_val;
   logic [7:0]        a_exp;
   logic [26:0]       a_mant, b_mant;
   logic              add_sign;
   logic [27:0]       add_sum;
   logic              nm_zero;
   logic signed [9:0] nm_exp;
   logic [26:0]       nm_mant;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (in_valid) state_next = S_ALIGN;
         S_ALIGN: state_next = S_ADD;
         S_ADD:   state_next = S_NORM;
         S_NORM:  state_next = S_PACK;
         S_PACK:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign in_ready = (state == S_IDLE);

   // ALIGN: unpack with zero flush, put the larger exponent in A, shift B into {mant,G,R,S}.
   fp32_t       x, y;
   logic        x_sign, y_sign, swap, special;
   logic [23:0] x_mant, y_mant, small_mant;
   logic [7:0]  big_exp, small_exp, diff;
   logic [53:0] shift_full;
   logic [26:0] small_field;
   logic [31:0] special_val;

   always_comb begin
      x          = acc;
      y          = cap_p;
      x_sign     = (x.exp != 8'd0) & x.sign;
      y_sign     = (y.exp != 8'd0) & y.sign;
      x_mant     = (x.exp != 8'd0) ? {1'b1, x.man} : 24'd0;
      y_mant     = (y.exp != 8'd0) ? {1'b1, y.man} : 24'd0;
      swap       = y.exp > x.exp;
      big_exp    = swap ? y.exp : x.exp;
      small_exp  = swap ? x.exp : y.exp;
      small_mant = swap ? x_mant : y_mant;
      diff       = big_exp - small_exp;
      shift_full = {small_mant, 30'd0} >> diff;
      if (diff >= 8'd27) small_field = {26'd0, |small_mant};
      else               small_field = {shift_full[53:28], shift_full[27] | (|shift_full[26:0])};
      special     = (x.exp == 8'hFF) | (y.exp == 8'hFF);
      special_val = '0;
      if ((x.exp == 8'hFF) && (y.exp == 8'hFF))
         special_val = (x.sign != y.sign) ? QNAN : (x.sign ? NEG_INF : POS_INF);
      else if (x.exp == 8'hFF)
         special_val = x.sign ? NEG_INF : POS_INF;
      else if (y.exp == 8'hFF)
         special_val = y.sign ? NEG_INF : POS_INF;
   end

   // ADD: magnitude add, or larger-minus-smaller with the larger operand's sign.
   logic [27:0] sum_c;
   logic        sum_sign_c;

   always_comb begin
      if (a_sign == b_sign) begin
         sum_c      = {1'b0, a_mant} + {1'b0, b_mant};
         sum_sign_c = a_sign;
      end else if (a_mant >= b_mant) begin
         sum_c      = {1'b0, a_mant} - {1'b0, b_mant};
         sum_sign_c = a_sign;
      end else begin
         sum_c      = {1'b0, b_mant} - {1'b0, a_mant};
         sum_sign_c = b_sign;
      end
   end

   // NORM: the hidden bit is brought back to bit 26 of the 27-bit field.
   logic [4:0]        lz;
   logic [27:0]       sum_shl;
   logic signed [9:0] norm_exp_c;
   logic [26:0]       norm_mant_c;

   fp_lzc u_lzc (
      .value (add_sum),
      .count (lz)
   );

   always_comb begin
      sum_shl = add_sum << lz;
      if (add_sum[27]) begin
         norm_mant_c = {add_sum[27:2], |add_sum[1:0]};
         norm_exp_c  = $signed({2'b00, a_exp}) + 10'sd1;
      end else begin
         norm_mant_c = sum_shl[27:1];
         norm_exp_c  = $signed({2'b00, a_exp}) - $signed({5'd0, lz}) + 10'sd1;
      end
   end

   // PACK: rounding, then saturation / underflow flush.
   logic [23:0]       pk_mant;
   logic signed [9:0] pk_exp;
   logic [31:0]       result;
   logic              unused_bits;

`ifdef FP_ACC_RNE_EN
   logic        round_up;
   logic [24:0] rounded;

   always_comb begin
      round_up = nm_mant[2] & (nm_mant[3] | nm_mant[1] | nm_mant[0]);
      rounded  = {1'b0, nm_mant[26:3]} + {24'd0, round_up};
      if (rounded[24]) begin
         pk_mant = rounded[24:1];
         pk_exp  = nm_exp + 10'sd1;
      end else begin
         pk_mant = rounded[23:0];
         pk_exp  = nm_exp;
      end
   end

   assign unused_bits = ^{sum_shl[0], pk_mant[23]};
`else
   assign pk_mant     = nm_mant[26:3];
   assign pk_exp      = nm_exp;
   assign unused_bits = ^{sum_shl[0], pk_mant[23], nm_mant[2:0]};
`endif

   always_comb begin
      if (al_special)                        result = al_special_val;
      else if (nm_zero || pk_exp <= 10'sd0)  result = '0;
      else if (pk_exp >= EXP_SAT)            result = add_sign ? NEG_INF : POS_INF;
      else                                   result = {add_sign, pk_exp[7:0], pk_mant[22:0]};
   end

   // NOTE: pipeline datapath registers carry no reset; each is rewritten before the FSM reads it.
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: if (in_valid) begin
            cap_p    <= in_p;
            cap_last <= in_last;
         end
         S_ALIGN: begin
            al_special     <= special;
            al_special_val <= special_val;
            a_sign         <= swap ? y_sign : x_sign;
            b_sign         <= swap ? x_sign : y_sign;
            a_exp          <= big_exp;
            a_mant         <= {(swap ? y_mant : x_mant), 3'b000};
            b_mant         <= small_field;
         end
         S_ADD: begin
            add_sum  <= sum_c;
            add_sign <= sum_sign_c;
         end
         S_NORM: begin
            nm_zero <= (add_sum == 28'd0);
            nm_exp  <= norm_exp_c;
            nm_mant <= norm_mant_c;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc       <= '0;
         out_sum   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (state == S_PACK) begin
            if (cap_last) begin
               acc       <= '0;
               out_sum   <= result;
               out_valid <= 1'b1;
            end else begin
               acc <= result;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_acc.sv
// tb_fp_acc: table-driven directed vectors for fp_acc plus stream/backpressure and reset-abort
// sequences. Expected sums follow FP_ACC_RNE_EN when it is defined.
module tb_fp_acc;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_p;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_sum;
   logic        out_valid;

   int tests;
   int failed;
   int cyc;
   int xfer_cyc;

   fp_acc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_p      (in_p),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_sum   (out_sum),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [2:0]  n;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [31:0] p3;
      logic [31:0] want;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] n, input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] p2, input logic [31:0] p3, input logic [31:0] want);
      vec_t v;
      v.n = n; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.want = want;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send(input logic [31:0] p, input logic last);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_p     = p;
      in_last  = last;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("send in_ready timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      xfer_cyc = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_result(input string name, input logic [31:0] want);
      int   waited;
      logic held;
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({name, " out_valid seen"}, {31'd0, out_valid}, 32'd1);
      check({name, " sum"}, out_sum, want);
      check({name, " latency"}, 32'(cyc - xfer_cyc), 32'd4);
      held = out_valid;
      @(negedge clk);
      if (held) begin
         check({name, " pulse width"}, {31'd0, out_valid}, 32'd0);
         check({name, " sum held"}, out_sum, want);
      end
   endtask

   vec_t vecs[14];

   initial begin
      tests    = 0;
      failed   = 0;
      xfer_cyc = 0;

      vecs[0]  = mk(3'd4, 32'h4080_0000, 32'h4180_0000, 32'h4280_0000, 32'h4380_0000, 32'h43AA_0000);
      vecs[1]  = mk(3'd1, 32'h3F80_0000, 32'h0, 32'h0, 32'h0, 32'h3F80_0000);
      vecs[2]  = mk(3'd2, 32'h4040_0000, 32'hC040_0000, 32'h0, 32'h0, 32'h0000_0000);
`ifdef FP_ACC_RNE_EN
      vecs[3]  = mk(3'd2, 32'h3F80_0001, 32'h3380_0000, 32'h0, 32'h0, 32'h3F80_0002);
      vecs[11] = mk(3'd2, 32'h4F80_0000, 32'hBF80_0000, 32'h0, 32'h0, 32'h4F80_0000);
`else
      vecs[3]  = mk(3'd2, 32'h3F80_0001, 32'h3380_0000, 32'h0, 32'h0, 32'h3F80_0001);
      vecs[11] = mk(3'd2, 32'h4F80_0000, 32'hBF80_0000, 32'h0, 32'h0, 32'h4F7F_FFFF);
`endif
      vecs[4]  = mk(3'd1, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0000_0000);
      vecs[5]  = mk(3'd2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0, 32'h0, 32'h7F80_0000);
      vecs[6]  = mk(3'd2, 32'h7F80_0000, 32'hFF80_0000, 32'h0, 32'h0, 32'h7FC0_0000);
      vecs[7]  = mk(3'd2, 32'h3F80_0000, 32'hBF00_0000, 32'h0, 32'h0, 32'h3F00_0000);
      vecs[8]  = mk(3'd2, 32'h3FC0_0000, 32'h4000_0000, 32'h0, 32'h0, 32'h4060_0000);
      vecs[9]  = mk(3'd2, 32'hC000_0000, 32'h3F00_0000, 32'h0, 32'h0, 32'hBFC0_0000);
      vecs[10] = mk(3'd2, 32'h00C0_0000, 32'h8080_0000, 32'h0, 32'h0, 32'h0000_0000);
      vecs[12] = mk(3'd2, 32'h4B80_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h4B80_0000);
      vecs[13] = mk(3'd2, 32'h7F80_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h7F80_0000);

      // Reset for one edge.
      rst      = 1'b0;
      in_valid = 1'b0;
      in_p     = '0;
      in_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("reset out_sum", out_sum, 32'd0);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 14; i++) begin
         logic [31:0] ps[4];
         ps[0] = vecs[i].p0; ps[1] = vecs[i].p1; ps[2] = vecs[i].p2; ps[3] = vecs[i].p3;
         for (int k = 0; k < int'(vecs[i].n); k++)
            send(ps[k], (k == int'(vecs[i].n) - 1));
         get_result($sformatf("vec%0d", i), vecs[i].want);
      end

      // Continuous in_valid with a new product each cycle: only slots 0, 5, 10 are accepted.
      for (int i = 0; i <= 10; i++) begin
         in_valid = 1'b1;
         case (i)
            0:       begin in_p = 32'h3F80_0000; in_last = 1'b0; end
            5:       begin in_p = 32'h4000_0000; in_last = 1'b0; end
            10:      begin in_p = 32'h4080_0000; in_last = 1'b1; end
            default: begin in_p = 32'h42C8_0000; in_last = 1'b1; end
         endcase
         #1;
         check($sformatf("stream in_ready slot %0d", i), {31'd0, in_ready}, {31'd0, (i % 5 == 0)});
         @(posedge clk);
         @(negedge clk);
      end
      xfer_cyc = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
      get_result("stream", 32'h40E0_0000);

      // Reset while the second product of a sum is in ADD, then restart cleanly.
      send(32'h4000_0000, 1'b0);
      repeat (4) @(negedge clk);
      send(32'h4040_0000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("abort in_ready", {31'd0, in_ready}, 32'd1);
      check("abort out_valid", {31'd0, out_valid}, 32'd0);
      check("abort out_sum", out_sum, 32'd0);
      send(32'h3F80_0000, 1'b1);
      get_result("after abort", 32'h3F80_0000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
